// File: rtl/hwpe_ctrl_ctx_regfile.sv
// Multi-context HWPE control register file: round-robin context allocation, in-order job issue to the engine.
// Optional per-job cycle counter: define HWPE_CTRL_CTX_REGFILE_PERF_CNT_EN.
module hwpe_ctrl_ctx_regfile #(
  parameter int N_CONTEXT      = 2,
  parameter int N_IO_REGS      = 8,
  parameter int N_GENERIC_REGS = 4,
  parameter int ID_WIDTH       = 16,
  parameter int JOB_ID_WIDTH   = 8,
  localparam int CW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
  localparam int NG = (N_GENERIC_REGS > 0) ? N_GENERIC_REGS : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    req_i,
  input  logic                    wen_i,
  input  logic [5:0]              addr_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              be_i,
  input  logic [ID_WIDTH-1:0]     src_i,
  output logic                    r_valid_o,
  output logic [31:0]             r_data_o,
  output logic                    start_o,
  input  logic                    done_i,
  output logic                    busy_o,
  output logic                    evt_o,
  output logic [CW-1:0]           ctx_running_o,
  output logic [N_IO_REGS*32-1:0] hwpe_params_o,
  output logic [NG*32-1:0]        generic_params_o
);

  localparam int IW = (N_IO_REGS > 1) ? $clog2(N_IO_REGS) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST_CTX = CW'(N_CONTEXT - 1);

  localparam logic [5:0] ADDR_TRIGGER  = 6'h00;
  localparam logic [5:0] ADDR_ACQUIRE  = 6'h01;
  localparam logic [5:0] ADDR_FINISHED = 6'h02;

  typedef enum logic [1:0] {
    CTX_FREE     = 2'd0,
    CTX_ACQUIRED = 2'd1,
    CTX_QUEUED   = 2'd2,
    CTX_RUNNING  = 2'd3
  } ctx_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] ptr_next(input logic [CW-1:0] p);
    return (p == LAST_CTX) ? {CW{1'b0}} : p + CW'(1'b1);
  endfunction

  ctx_state_e              ctx_state_r [N_CONTEXT];
  ctx_state_e              ctx_state_s [N_CONTEXT];
  logic [CW-1:0]           alloc_ptr_r, issue_ptr_r, run_ptr_r;
  logic [31:0]             io_regs_r  [N_CONTEXT][N_IO_REGS];
  logic [31:0]             gen_regs_r [NG];
  logic [ID_WIDTH-1:0]     src_r      [N_CONTEXT];
  logic [JOB_ID_WIDTH-1:0] job_id_r, running_job_id_r;
  logic [1:0]              finished_r, finished_s;
  logic [N_IO_REGS*32-1:0] params_r;
  logic                    r_valid_r, evt_r, busy_r;
  logic [31:0]             r_data_r, rdata_s, status_s, perf_rd_s;
  logic                    rd_s, wr_s, any_running_s, busy_s, issue_s, acq_s, trig_s, done_s;
  logic                    io_wr_s, gen_wr_s, io_range_s, gen_range_s;
  ctx_state_e              alloc_state_s;
  logic [IW-1:0]           io_idx_s;
  logic [GW-1:0]           gen_idx_s;

  assign rd_s          = req_i & ~wen_i;
  assign wr_s          = req_i & wen_i;
  assign io_idx_s      = addr_i[IW-1:0];
  assign gen_idx_s     = addr_i[GW-1:0];
  assign io_range_s    = addr_i[5] && ({27'd0, addr_i[4:0]} < 32'(N_IO_REGS));
  assign gen_range_s   = (addr_i[5:4] == 2'b01) && ({28'd0, addr_i[3:0]} < 32'(N_GENERIC_REGS));
  assign alloc_state_s = ctx_state_r[alloc_ptr_r];

  // Operations on the three pointed-to contexts never target the same context at once
  assign issue_s  = ~any_running_s & (ctx_state_r[issue_ptr_r] == CTX_QUEUED);
  assign acq_s    = rd_s & (addr_i == ADDR_ACQUIRE) & (alloc_state_s == CTX_FREE);
  assign trig_s   = wr_s & (addr_i == ADDR_TRIGGER) & (alloc_state_s == CTX_ACQUIRED);
  assign done_s   = done_i & any_running_s;
  assign io_wr_s  = wr_s & io_range_s & (alloc_state_s == CTX_ACQUIRED);
  assign gen_wr_s = wr_s & gen_range_s;

  // Per-context lifecycle next state
  always_comb begin
    for (int c = 0; c < N_CONTEXT; c++) begin
      ctx_state_s[c] = ctx_state_r[c];
      case (ctx_state_r[c])
        CTX_FREE:     ctx_state_s[c] = (acq_s && alloc_ptr_r == CW'(c)) ? CTX_ACQUIRED : CTX_FREE;
        CTX_ACQUIRED: ctx_state_s[c] = (trig_s && alloc_ptr_r == CW'(c)) ? CTX_QUEUED : CTX_ACQUIRED;
        CTX_QUEUED:   ctx_state_s[c] = (issue_s && issue_ptr_r == CW'(c)) ? CTX_RUNNING : CTX_QUEUED;
        CTX_RUNNING:  ctx_state_s[c] = (done_s && run_ptr_r == CW'(c)) ? CTX_FREE : CTX_RUNNING;
        default:      ctx_state_s[c] = CTX_FREE;
      endcase
    end
  end

  // Activity flags and packed status word
  always_comb begin
    any_running_s = 1'b0;
    busy_s        = 1'b0;
    status_s      = 32'd0;
    for (int c = 0; c < N_CONTEXT; c++) begin
      any_running_s        = any_running_s | (ctx_state_r[c] == CTX_RUNNING);
      busy_s               = busy_s | (ctx_state_s[c] == CTX_QUEUED) | (ctx_state_s[c] == CTX_RUNNING);
      status_s[2*c +: 2]   = ctx_state_r[c];
    end
  end

  // Finished counter: a same-cycle read sees the old value, the done still counts
  always_comb begin
    finished_s = finished_r;
    if (rd_s && addr_i == ADDR_FINISHED) finished_s = 2'd0;
    else                                 finished_s = finished_r;
    if (done_s && finished_s != 2'd3)    finished_s = finished_s + 2'd1;
    else                                 finished_s = finished_s;
  end

  // Read data mux on request-cycle state
  always_comb begin
    rdata_s = 32'hDEADBEEF;
    if (addr_i[5]) begin
      if (io_range_s) rdata_s = io_regs_r[alloc_ptr_r][io_idx_s];
      else            rdata_s = 32'hDEADBEEF;
    end else if (addr_i[4]) begin
      if (gen_range_s) rdata_s = gen_regs_r[gen_idx_s];
      else             rdata_s = 32'hDEADBEEF;
    end else begin
      case (addr_i[3:0])
        4'd1: begin
          if (alloc_state_s == CTX_ACQUIRED)  rdata_s = 32'hFFFFFFFE;
          else if (alloc_state_s != CTX_FREE) rdata_s = 32'hFFFFFFFF;
          else                                rdata_s = 32'(job_id_r);
        end
        4'd2:    rdata_s = {30'd0, finished_r};
        4'd3:    rdata_s = status_s;
        4'd4:    rdata_s = 32'(running_job_id_r);
        4'd5:    rdata_s = 32'(src_r[alloc_ptr_r]);
        4'd7:    rdata_s = perf_rd_s;
        default: rdata_s = 32'hDEADBEEF;
      endcase
    end
  end

  // Context state, register storage, pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int c = 0; c < N_CONTEXT; c++) begin
        ctx_state_r[c] <= CTX_FREE;
        src_r[c]       <= '0;
        for (int k = 0; k < N_IO_REGS; k++) io_regs_r[c][k] <= 32'd0;
      end
      for (int g = 0; g < NG; g++) gen_regs_r[g] <= 32'd0;
      alloc_ptr_r      <= '0;
      issue_ptr_r      <= '0;
      run_ptr_r        <= '0;
      job_id_r         <= '0;
      running_job_id_r <= '0;
      finished_r       <= 2'd0;
      params_r         <= '0;
      r_valid_r        <= 1'b0;
      r_data_r         <= 32'd0;
      evt_r            <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      for (int c = 0; c < N_CONTEXT; c++) ctx_state_r[c] <= ctx_state_s[c];
      busy_r     <= busy_s;
      evt_r      <= done_s;
      finished_r <= finished_s;
      r_valid_r  <= rd_s;
      r_data_r   <= rd_s ? rdata_s : 32'd0;
      if (acq_s) begin
        src_r[alloc_ptr_r] <= src_i;
        job_id_r           <= job_id_r + JOB_ID_WIDTH'(1'b1);
      end
      if (trig_s) alloc_ptr_r <= ptr_next(alloc_ptr_r);
      // Snapshot of the issued context so the engine view holds past done
      if (issue_s) begin
        issue_ptr_r <= ptr_next(issue_ptr_r);
        run_ptr_r   <= issue_ptr_r;
        for (int k = 0; k < N_IO_REGS; k++) params_r[32*k +: 32] <= io_regs_r[issue_ptr_r][k];
      end
      if (done_s)   running_job_id_r <= running_job_id_r + JOB_ID_WIDTH'(1'b1);
      if (io_wr_s)  io_regs_r[alloc_ptr_r][io_idx_s] <= be_merge(io_regs_r[alloc_ptr_r][io_idx_s], wdata_i, be_i);
      if (gen_wr_s) gen_regs_r[gen_idx_s] <= be_merge(gen_regs_r[gen_idx_s], wdata_i, be_i);
    end
  end

`ifdef HWPE_CTRL_CTX_REGFILE_PERF_CNT_EN
  logic [31:0] perf_cnt_r, perf_r, perf_inc_s;

  assign perf_inc_s = (perf_cnt_r == 32'hFFFFFFFF) ? perf_cnt_r : perf_cnt_r + 32'd1;

  // Cycles spent RUNNING by the current job, captured on completion
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      perf_cnt_r <= 32'd0;
      perf_r     <= 32'd0;
    end else begin
      if (issue_s)            perf_cnt_r <= 32'd0;
      else if (any_running_s) perf_cnt_r <= perf_inc_s;
      if (done_s)             perf_r     <= perf_inc_s;
    end
  end

  assign perf_rd_s = perf_r;
`else
  assign perf_rd_s = 32'd0;
`endif

  generate
    if (N_GENERIC_REGS > 0) begin : g_gen_out
      for (genvar g = 0; g < NG; g++) begin : g_word
        assign generic_params_o[32*g +: 32] = gen_regs_r[g];
      end
    end else begin : g_no_gen
      assign generic_params_o = '0;
    end
  endgenerate

  assign start_o       = issue_s & ~rst_i & ~clear_i;
  assign r_valid_o     = r_valid_r;
  assign r_data_o      = r_data_r;
  assign busy_o        = busy_r;
  assign evt_o         = evt_r;
  assign ctx_running_o = run_ptr_r;
  assign hwpe_params_o = params_r;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_regfile.sv
// Bench for hwpe_ctrl_ctx_regfile: directed job lifecycle scenarios, then random traffic,
// all compared against a queue-based model of the context lifecycle.
module tb_hwpe_ctrl_ctx_regfile;

  localparam int NC  = 2;
  localparam int NIO = 8;
  localparam int NG  = 4;
  localparam int IDW = 16;
  localparam int JW  = 2;

  logic            clk_i = 1'b0;
  logic            rst_i, clear_i, req_i, wen_i, done_i;
  logic [5:0]      addr_i;
  logic [31:0]     wdata_i;
  logic [3:0]      be_i;
  logic [IDW-1:0]  src_i;
  logic            r_valid_o, start_o, busy_o, evt_o;
  logic [31:0]     r_data_o;
  logic [0:0]      ctx_running_o;
  logic [NIO*32-1:0] hwpe_params_o;
  logic [NG*32-1:0]  generic_params_o;

  hwpe_ctrl_ctx_regfile #(
    .N_CONTEXT(NC), .N_IO_REGS(NIO), .N_GENERIC_REGS(NG), .ID_WIDTH(IDW), .JOB_ID_WIDTH(JW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .req_i(req_i), .wen_i(wen_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i), .src_i(src_i),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .start_o(start_o), .done_i(done_i),
    .busy_o(busy_o), .evt_o(evt_o), .ctx_running_o(ctx_running_o),
    .hwpe_params_o(hwpe_params_o), .generic_params_o(generic_params_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: lifecycle states per context, a FIFO of triggered contexts
  int          m_st [NC];
  int          m_alloc, m_run, m_cur, m_job, m_rjob, m_fin, m_perf, m_start_cyc, cyc;
  int          m_q [$];
  logic [31:0] m_io [NC][NIO];
  logic [31:0] m_gen [NG];
  logic [15:0] m_src [NC];
  logic [31:0] m_params [NIO];

  logic        obs_start, obs_evt;
  logic [31:0] obs_rdata;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_st[c] = 0; m_src[c] = 16'd0;
      for (int k = 0; k < NIO; k++) m_io[c][k] = 32'd0;
    end
    for (int g = 0; g < NG; g++) m_gen[g] = 32'd0;
    for (int k = 0; k < NIO; k++) m_params[k] = 32'd0;
    m_q.delete();
    m_alloc = 0; m_run = -1; m_cur = 0; m_job = 0; m_rjob = 0; m_fin = 0; m_perf = 0; m_start_cyc = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int ai = int'(a);
    logic [31:0] st = 32'd0;
    if (ai == 1) begin
      if (m_st[m_alloc] == 1)      return 32'hFFFFFFFE;
      else if (m_st[m_alloc] != 0) return 32'hFFFFFFFF;
      else                         return 32'(m_job);
    end
    if (ai == 2) return 32'(m_fin);
    if (ai == 3) begin
      for (int c = 0; c < NC; c++) st = st | (32'(m_st[c]) << (2 * c));
      return st;
    end
    if (ai == 4) return 32'(m_rjob);
    if (ai == 5) return {16'd0, m_src[m_alloc]};
`ifdef HWPE_CTRL_CTX_REGFILE_PERF_CNT_EN
    if (ai == 7) return 32'(m_perf);
`else
    if (ai == 7) return 32'd0;
`endif
    if (ai >= 16 && ai < 16 + NG) return m_gen[ai - 16];
    if (ai >= 32 && ai < 32 + NIO) return m_io[m_alloc][ai - 32];
    return 32'hDEADBEEF;
  endfunction

  task automatic step(input logic req, input logic wen, input logic [5:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [15:0] src, input logic done, input logic clr);
    logic [31:0] exp_rd;
    logic        exp_rv, exp_start, exp_evt, exp_busy;
    int          ai;
    ai = int'(addr);
    req_i = req; wen_i = wen; addr_i = addr; wdata_i = wdata; be_i = be; src_i = src;
    done_i = done; clear_i = clr;
    @(negedge clk_i);
    exp_start = (m_run < 0) && (m_q.size() > 0);
    obs_start = start_o;
    if (!clr) chk("start", 32'(start_o), 32'(exp_start));
    exp_rv  = req && !wen && !clr;
    exp_rd  = exp_rv ? model_read(addr) : 32'd0;
    exp_evt = 1'b0;
    if (clr) model_reset();
    else begin
      if (req && !wen && ai == 2) m_fin = 0;
      if (exp_start) begin
        m_run = m_q.pop_front();
        m_st[m_run] = 3; m_cur = m_run; m_start_cyc = cyc;
        for (int k = 0; k < NIO; k++) m_params[k] = m_io[m_run][k];
      end else if (done && m_run >= 0) begin
        m_st[m_run] = 0; m_run = -1; exp_evt = 1'b1;
        m_rjob = (m_rjob + 1) % (1 << JW);
        m_fin  = (m_fin < 3) ? m_fin + 1 : 3;
        m_perf = cyc - m_start_cyc;
      end
      if (req && !wen && ai == 1 && m_st[m_alloc] == 0) begin
        m_st[m_alloc] = 1; m_src[m_alloc] = src; m_job = (m_job + 1) % (1 << JW);
      end
      if (req && wen && ai == 0 && m_st[m_alloc] == 1) begin
        m_st[m_alloc] = 2; m_q.push_back(m_alloc); m_alloc = (m_alloc + 1) % NC;
      end
      if (req && wen && ai >= 32 && ai < 32 + NIO && m_st[m_alloc] == 1)
        m_io[m_alloc][ai - 32] = merge(m_io[m_alloc][ai - 32], wdata, be);
      if (req && wen && ai >= 16 && ai < 16 + NG)
        m_gen[ai - 16] = merge(m_gen[ai - 16], wdata, be);
    end
    exp_busy = 1'b0;
    for (int c = 0; c < NC; c++) if (m_st[c] >= 2) exp_busy = 1'b1;
    @(posedge clk_i); #1;
    cyc++;
    obs_rdata = r_data_o;
    obs_evt   = evt_o;
    chk("r_valid", 32'(r_valid_o), 32'(exp_rv));
    if (exp_rv || clr) chk("r_data", r_data_o, exp_rd);
    chk("evt", 32'(evt_o), 32'(exp_evt));
    chk("busy", 32'(busy_o), 32'(exp_busy));
    chk("ctx_running", 32'(ctx_running_o), 32'(m_cur));
    for (int k = 0; k < NIO; k++) chk("params", hwpe_params_o[32*k +: 32], m_params[k]);
    for (int g = 0; g < NG; g++) chk("generic", generic_params_o[32*g +: 32], m_gen[g]);
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] s);
    step(1'b1, 1'b0, a, $urandom, 4'hF, s, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, 1'b1, a, d, be, 16'd0, 1'b0, 1'b0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 16'd0, 1'b0, 1'b0);
  endtask
  task automatic pulse_done();
    step(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 16'd0, 1'b1, 1'b0);
  endtask

  // One full job on an idle engine; done arrives `hold` cycles after start
  task automatic run_job(input int hold, output logic [31:0] acq_val);
    rd(6'h01, 16'($urandom));
    acq_val = obs_rdata;
    wr(6'(32 + $urandom_range(0, NIO - 1)), $urandom, 4'($urandom));
    wr(6'h00, 32'd0, 4'hF);
    idle();
    repeat (hold - 1) idle();
    pulse_done();
  endtask

  initial begin
    logic [31:0] v;
    logic [5:0]  a;
    int          r;
    rst_i = 1'b1; clear_i = 1'b0; req_i = 1'b0; wen_i = 1'b0; done_i = 1'b0;
    addr_i = 6'd0; wdata_i = 32'd0; be_i = 4'h0; src_i = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_r_valid", 32'(r_valid_o), 32'd0);
    chk("rst_r_data", r_data_o, 32'd0);
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_evt", 32'(evt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ctx_running", 32'(ctx_running_o), 32'd0);
    for (int k = 0; k < NIO; k++) chk("rst_params", hwpe_params_o[32*k +: 32], 32'd0);
    for (int g = 0; g < NG; g++) chk("rst_generic", generic_params_o[32*g +: 32], 32'd0);
    rst_i = 1'b0;

    rd(6'h01, 16'd3);          chk("plan_acq0", obs_rdata, 32'd0);
    rd(6'h03, 16'd0);          chk("plan_status_acq", obs_rdata, 32'h1);
    rd(6'h05, 16'd0);          chk("plan_src", obs_rdata, 32'd3);
    rd(6'h01, 16'd5);          chk("plan_acq_other_pe", obs_rdata, 32'hFFFFFFFE);
    wr(6'h20, 32'hA5A5A5A5, 4'b0011);
    wr(6'h00, 32'd0, 4'hF);
    idle();                    chk("plan_start", 32'(obs_start), 32'd1);
    chk("plan_params", hwpe_params_o[31:0], 32'h0000A5A5);
    rd(6'h03, 16'd0);          chk("plan_status_run", obs_rdata, 32'h3);
    rd(6'h01, 16'd7);          chk("plan_acq1", obs_rdata, 32'd1);
    wr(6'h21, 32'h12345678, 4'hF);
    wr(6'h00, 32'd0, 4'hF);
    rd(6'h01, 16'd9);          chk("plan_all_busy", obs_rdata, 32'hFFFFFFFF);
    pulse_done();              chk("plan_evt", 32'(obs_evt), 32'd1);
    idle();                    chk("plan_next_start", 32'(obs_start), 32'd1);
    chk("plan_ctx1_running", 32'(ctx_running_o), 32'd1);
    rd(6'h04, 16'd0);          chk("plan_running_job_id", obs_rdata, 32'd1);
    pulse_done();
    run_job(3, v);             chk("plan_acq2", v, 32'd2);
    run_job(4, v);             chk("plan_acq3", v, 32'd3);
    rd(6'h02, 16'd0);          chk("plan_finished_sat", obs_rdata, 32'd3);
    rd(6'h02, 16'd0);          chk("plan_finished_clr", obs_rdata, 32'd0);
    run_job(10, v);            chk("plan_jobid_wrap", v, 32'd0);
    rd(6'h07, 16'd0);
`ifdef HWPE_CTRL_CTX_REGFILE_PERF_CNT_EN
    chk("plan_perf", obs_rdata, 32'd10);
`else
    chk("plan_perf", obs_rdata, 32'd0);
`endif
    rd(6'h01, 16'd1);
    wr(6'h00, 32'd0, 4'hF);
    idle();
    idle();
    step(1'b0, 1'b0, 6'd0, 32'd0, 4'h0, 16'd0, 1'b0, 1'b1);
    rd(6'h03, 16'd0);          chk("plan_clear_status", obs_rdata, 32'd0);
    chk("plan_clear_busy", 32'(busy_o), 32'd0);
    idle();                    chk("plan_clear_nostart", 32'(obs_start), 32'd0);

    repeat (3000) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1, 2: a = 6'h01;
        3, 4:    a = 6'h00;
        5, 6, 7: a = 6'(32 + $urandom_range(0, NIO + 1));
        8, 9:    a = 6'(16 + $urandom_range(0, NG + 1));
        10:      a = 6'h03;
        11:      a = 6'h02;
        12:      a = 6'h04;
        13:      a = 6'h05;
        14:      a = 6'h07;
        default: a = 6'($urandom_range(0, 63));
      endcase
      step($urandom_range(0, 9) < 8,
           (r >= 3 && r <= 5) || (r == 8) || (r >= 15 && $urandom_range(0, 1) == 1),
           a, $urandom, 4'($urandom), 16'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
